cs_resolver: RTL



---
 rtl/cs_resolver_pkg.sv | 24 ++
 rtl/cs_resolver_if.sv | 23 ++
 rtl/cs_resolver_chunk_adder.sv | 12 +
 rtl/cs_resolver.sv | 122 ++++++++++++
 4 files changed

// File: rtl/cs_resolver_pkg.sv
// Shared types and sizing helpers for the carry-save resolver.
package cs_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
      return (a + b - 1) / b;
   endfunction

   // Number of W-bit chunks needed to cover an (N+1)-bit operand.
   function automatic int unsigned chunk_count(input int unsigned n, input int unsigned w);
      return ceil_div(n + 1, w);
   endfunction

   // Chunk counter width, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned k);
      return (k <= 1) ? 1 : $clog2(k);
   endfunction

endpackage

// File: rtl/cs_resolver_if.sv
// Operand/result handshake bundle for the carry-save resolver.
interface cs_resolver_if #(
   parameter int unsigned N = 256
);
   logic [N:0] s;
   logic [N:0] c;
   logic       in_valid;
   logic       in_ready;
   logic [N:0] r;
   logic       cout;
   logic       out_valid;
   logic       out_ready;

   modport master (
      output s, c, in_valid, out_ready,
      input  in_ready, r, cout, out_valid
   );

   modport slave (
      input  s, c, in_valid, out_ready,
      output in_ready, r, cout, out_valid
   );
endinterface

// File: rtl/cs_resolver_chunk_adder.sv
// W-bit carry-propagate adder with carry-in/carry-out; purely combinational.
module cs_chunk_adder #(
   parameter int unsigned W = 64
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] sum,
   output logic         co
);
   assign {co, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
endmodule

// File: rtl/cs_resolver.sv
// Sequential carry-save to binary converter: resolves s + c one W-bit chunk
// per cycle, least-significant chunk first, through a single chunk adder.
module cs_resolver
   import cs_pkg::*;
#(
   parameter int unsigned N = 256,
   parameter int unsigned W = 64
) (
   input  logic          clk,
   input  logic          rst,
   cs_resolver_if.slave  bus
);

   localparam int unsigned K     = chunk_count(N, W);
   localparam int unsigned CW    = cnt_width(K);
   localparam int unsigned PW    = K * W;
   // Live (non-padding) bits in the last chunk; bit LB of that chunk's
   // result is the carry out of operand bit N.
   localparam int unsigned LB    = N + 1 - (K - 1) * W;
   localparam logic [CW-1:0] KLAST = CW'(K - 1);

   state_t        state;
   logic [N:0]    s_q;
   logic [N:0]    c_q;
   logic [N:0]    r_q;
   logic [PW-1:0] s_pad;
   logic [PW-1:0] c_pad;
   logic [CW-1:0] cnt;
   logic          carry;
   logic          cout_q;
   logic          ovld_q;
   logic [W-1:0]  a_chk;
   logic [W-1:0]  b_chk;
   logic [W-1:0]  sum;
   logic          co;
   logic          cout_nx;
   logic          in_rdy;
   logic          accept;

   assign s_pad = PW'(s_q);
   assign c_pad = PW'(c_q);

   assign in_rdy        = (state == IDLE) | ((state == DONE) & bus.out_ready);
   assign accept        = in_rdy & bus.in_valid;
   assign bus.in_ready  = in_rdy;
   assign bus.r         = r_q;
   assign bus.cout      = cout_q;
   assign bus.out_valid = ovld_q;

   // Select the operand chunk addressed by the chunk counter.
   always_comb begin
      a_chk = '0;
      b_chk = '0;
      for (int unsigned i = 0; i < K; i++) begin
         if (cnt == CW'(i)) begin
            a_chk = s_pad[i*W +: W];
            b_chk = c_pad[i*W +: W];
         end
      end
   end

   cs_chunk_adder #(.W(W)) u_add (
      .a   (a_chk),
      .b   (b_chk),
      .ci  (carry),
      .sum (sum),
      .co  (co)
   );

   if (LB == W) begin : g_full_last
      assign cout_nx = co;
   end else begin : g_pad_last
      assign cout_nx = sum[LB];
   end

   // Capture registers, FSM, chunk-addressed result writes and carry chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         s_q    <= '0;
         c_q    <= '0;
         r_q    <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         cout_q <= 1'b0;
         ovld_q <= 1'b0;
      end else begin
         if (accept) begin
            s_q   <= bus.s;
            c_q   <= bus.c;
            cnt   <= '0;
            carry <= 1'b0;
            state <= BUSY;
         end
         case (state)
            IDLE: ;
            BUSY: begin
               for (int unsigned i = 0; i + 1 < K; i++) begin
                  if (cnt == CW'(i)) r_q[i*W +: W] <= sum;
               end
               if (cnt == KLAST) begin
                  r_q[N:(K-1)*W] <= sum[LB-1:0];
                  cout_q         <= cout_nx;
                  ovld_q         <= 1'b1;
                  state          <= DONE;
               end else begin
                  cnt   <= cnt + 1'b1;
                  carry <= co;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  ovld_q <= 1'b0;
                  if (!bus.in_valid) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
